// File: rtl/seven_seg_pkg.sv
// Shared constants and the leading-zero blank mask for the seven-segment scan controller.
package seven_seg_pkg;

  localparam int SEG_W      = 7;
  localparam int NIB_W      = 4;
  localparam int MAX_DIGITS = 8;

  // Bit i is set when digit i is a leading zero. Digit 0 is never blanked.
  // Digits at or above 'digits' are ignored.
  function automatic logic [MAX_DIGITS-1:0] lz_blank_mask(
    input logic [NIB_W*MAX_DIGITS-1:0] val,
    input int                          digits
  );
    logic                  zero_above;
    logic [MAX_DIGITS-1:0] m;
    m          = '0;
    zero_above = 1'b1;
    for (int i = MAX_DIGITS-1; i >= 0; i--) begin
      if (i < digits) begin
        zero_above = zero_above & (val[NIB_W*i +: NIB_W] == '0);
        m[i]       = (i > 0) && zero_above;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/seven_seg_prescaler.sv
// Slot-rate prescaler: wraps every CLK_DIV enabled cycles and flags the last one.
module seven_seg_prescaler #(
  parameter int CLK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int                CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  assign tick = en && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_cnt <= '0;
    else if (!en || r_cnt == LAST) r_cnt <= '0;
    else                          r_cnt <= r_cnt + CNT_W'(1);
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed scan controller for a common-anode seven-segment display with a
// frame-synchronous shadow register so a new value never tears mid-frame.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int CLK_DIV  = 50000,
  parameter int BLANK_LZ = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [NIB_W*DIGITS-1:0] value_in,
  input  logic                    value_vld,
  output logic [NIB_W-1:0]        digit_bin,
  output logic [DIGITS-1:0]       anode_n,
  output logic                    frame_done
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic                          w_tick;
  logic                          w_boundary;
  logic                          w_blank;
  logic [DIGITS-1:0]             w_onehot;
  logic [DIGITS-1:0][NIB_W-1:0]  w_nibs;
  logic [NIB_W*MAX_DIGITS-1:0]   w_shadow_ext;
  logic [MAX_DIGITS-1:0]         w_mask;

  logic [IDX_W-1:0]              r_idx;
  logic [NIB_W*DIGITS-1:0]       r_shadow;
  logic [NIB_W*DIGITS-1:0]       r_pending;
  logic                          r_pend_flag;
  logic [NIB_W-1:0]              r_digit_bin;
  logic [DIGITS-1:0]             r_anode_n;
  logic                          r_frame_done;

  seven_seg_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (enable),
    .tick  (w_tick)
  );

  assign w_boundary = w_tick && (r_idx == IDX_W'(DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_idx <= '0;
    else if (!enable) r_idx <= '0;
    else if (w_tick)  r_idx <= w_boundary ? '0 : r_idx + IDX_W'(1);
  end

  // Loads are staged in r_pending and only committed at a frame boundary;
  // while dark there is no frame to tear, so they commit immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow    <= '0;
      r_pending   <= '0;
      r_pend_flag <= 1'b0;
    end else begin
      if (value_vld) r_pending <= value_in;
      if (!enable) begin
        if (value_vld) begin
          r_shadow    <= value_in;
          r_pend_flag <= 1'b0;
        end
      end else if (w_boundary) begin
        if (value_vld)        r_shadow <= value_in;
        else if (r_pend_flag) r_shadow <= r_pending;
        r_pend_flag <= 1'b0;
      end else if (value_vld) begin
        r_pend_flag <= 1'b1;
      end
    end
  end

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < DIGITS; i++) w_onehot[i] = (r_idx == IDX_W'(i));
  end

  assign w_nibs       = r_shadow;
  assign w_shadow_ext = (NIB_W*MAX_DIGITS)'(r_shadow);
  assign w_mask       = lz_blank_mask(w_shadow_ext, DIGITS);
  assign w_blank      = (BLANK_LZ != 0) && (|(w_mask & MAX_DIGITS'(w_onehot)));

  // Blank slots keep their full duration; only the anode stays off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digit_bin  <= '0;
      r_anode_n    <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_boundary;
      if (!enable || w_blank) begin
        r_digit_bin <= '0;
        r_anode_n   <= '1;
      end else begin
        r_digit_bin <= w_nibs[r_idx];
        r_anode_n   <= ~w_onehot;
      end
    end
  end

  assign digit_bin  = r_digit_bin;
  assign anode_n    = r_anode_n;
  assign frame_done = r_frame_done;

endmodule
